// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle controller (master) and the
// datapath plus instruction/data memory (slave).
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instruction;
  logic             Zero;
  logic             mem_ready;
  logic             ALUScr;
  logic             RegWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic [3:0]       ALUControl;
  logic             mem_req;
  logic             mem_we;
  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCBranch;
  logic             error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  instruction, Zero, mem_ready,
    output ALUScr, RegWrite, RegDst, MemtoReg, ALUControl,
           mem_req, mem_we, IorD, IRWrite, PCWrite, PCBranch,
           error, instr_count
  );

  modport slave (
    output instruction, Zero, mem_ready,
    input  ALUScr, RegWrite, RegDst, MemtoReg, ALUControl,
           mem_req, mem_we, IorD, IRWrite, PCWrite, PCBranch,
           error, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: sequences lw/sw/addi/beq/R-type through
// fetch..writeback, with a memory-timeout watchdog and a sticky error state.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_ctrl_if.master dp
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ADDR, S_EXEC_R, S_BRANCH,
    S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_ERROR
  } state_e;

  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [3:0] alu_ctrl;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       err;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctl_t             ctl_q;
  logic             mem_busy, tmo_hit;
  logic [4:0]       funct_dec;

  logic [5:0] opcode, funct;
  logic       unused_instr_bits;
  assign opcode            = dp.instruction[31:26];
  assign funct             = dp.instruction[5:0];
  assign unused_instr_bits = ^dp.instruction[25:6];

  // {legal, ALUControl} for an R-type funct field.
  function automatic logic [4:0] funct_decode(input logic [5:0] f);
    case (f)
      6'h20:   return {1'b1, 4'b0010};
      6'h22:   return {1'b1, 4'b0110};
      6'h24:   return {1'b1, 4'b0000};
      6'h25:   return {1'b1, 4'b0001};
      6'h2A:   return {1'b1, 4'b0111};
      default: return 5'b0_0000;
    endcase
  endfunction

  function automatic ctl_t outputs_for(input state_e s, input logic [3:0] r_alu);
    ctl_t o;
    o = '0;
    case (s)
      S_FETCH:  o.mem_req = 1'b1;
      S_ADDR:   begin o.alu_src = 1'b1; o.alu_ctrl = ALU_ADD; end
      S_EXEC_R: o.alu_ctrl = r_alu;
      S_WB_R:   begin o.alu_ctrl = r_alu; o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      S_WB_I:   begin o.alu_src = 1'b1; o.alu_ctrl = ALU_ADD; o.reg_write = 1'b1; end
      S_MEM_RD, S_MEM_WR: begin
        o.mem_req  = 1'b1;
        o.iord     = 1'b1;
        o.mem_we   = (s == S_MEM_WR);
        o.alu_src  = 1'b1;
        o.alu_ctrl = ALU_ADD;
      end
      S_WB_MEM: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      S_BRANCH: o.alu_ctrl = ALU_SUB;
      S_ERROR:  o.err = 1'b1;
      default:  o = '0;
    endcase
    return o;
  endfunction

  assign funct_dec = funct_decode(funct);
  assign mem_busy  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // A ready arriving on the same cycle the count would expire still completes.
  assign tmo_hit   = mem_busy && !dp.mem_ready && (tmo_q == TMO_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    count_d = count_q;
    tmo_d   = (mem_busy && !dp.mem_ready && !tmo_hit) ? tmo_q + 8'd1 : 8'd0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (dp.mem_ready) state_d = S_DECODE;
                else if (tmo_hit) state_d = S_ERROR;
      S_DECODE: case (opcode)
                  OP_RTYPE:               state_d = S_EXEC_R;
                  OP_LW, OP_SW, OP_ADDI:  state_d = S_ADDR;
                  OP_BEQ:                 state_d = S_BRANCH;
                  default:                state_d = S_ERROR;
                endcase
      S_EXEC_R: state_d = funct_dec[4] ? S_WB_R : S_ERROR;
      S_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD :
                          (opcode == OP_SW) ? S_MEM_WR : S_WB_I;
      S_MEM_RD: if (dp.mem_ready) state_d = S_WB_MEM;
                else if (tmo_hit) state_d = S_ERROR;
      S_MEM_WR: if (dp.mem_ready) begin
                  state_d = S_FETCH;
                  count_d = count_q + CNT_W'(1);
                end else if (tmo_hit) begin
                  state_d = S_ERROR;
                end
      S_BRANCH, S_WB_R, S_WB_I, S_WB_MEM: begin
        state_d = S_FETCH;
        count_d = count_q + CNT_W'(1);
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      count_q <= '0;
      ctl_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q <= state_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
      ctl_q   <= outputs_for(state_d, funct_dec[3:0]);
    end
  end

  assign dp.ALUScr      = ctl_q.alu_src;
  assign dp.RegWrite    = ctl_q.reg_write;
  assign dp.RegDst      = ctl_q.reg_dst;
  assign dp.MemtoReg    = ctl_q.mem_to_reg;
  assign dp.ALUControl  = ctl_q.alu_ctrl;
  assign dp.mem_req     = ctl_q.mem_req;
  assign dp.mem_we      = ctl_q.mem_we;
  assign dp.IorD        = ctl_q.iord;
  assign dp.error       = ctl_q.err;
  assign dp.instr_count = count_q;
  assign dp.IRWrite     = (state_q == S_FETCH) && dp.mem_ready;
  assign dp.PCWrite     = (state_q == S_FETCH) && dp.mem_ready;
  assign dp.PCBranch    = (state_q == S_BRANCH) && dp.Zero;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: a per-instruction cycle model predicts every control output
// each cycle; a few literal counts pin the model.
module tb_mips_multicycle_ctrl;

  localparam int T  = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [3:0] alu;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_branch;
    logic       err;
  } exp_t;

  logic clk, rst;
  mips_multicycle_ctrl_if #(.CNT_W(CW)) bus ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (bus.master)
  );

  always #5 clk = ~clk;

  int          checks, passes;
  int          cyc, req_cycles, we_cycles, regw_cycles;
  logic [CW-1:0] model_cnt;
  logic        died;

  function automatic logic [15:0] act();
    return {bus.ALUScr, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUControl,
            bus.mem_req, bus.mem_we, bus.IorD, bus.IRWrite, bus.PCWrite,
            bus.PCBranch, bus.error};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1ns later.
  task automatic cycle(input string name, input logic rdy, input logic zero, input exp_t e);
    bus.mem_ready = rdy;
    bus.Zero      = zero;
    #1;
    check(name, act(), e);
    check({name, "_count"}, bus.instr_count, model_cnt);
    cyc++;
    if (bus.mem_req)  req_cycles++;
    if (bus.mem_we)   we_cycles++;
    if (bus.RegWrite) regw_cycles++;
    @(negedge clk);
  endtask

  // Memory phase: ready after `wait_n` stall cycles, or watchdog expiry.
  task automatic mem_access(input string name, input int wait_n, input exp_t e,
                            input logic is_fetch, output logic dead);
    exp_t e2;
    logic rdy;
    dead = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rdy = (i >= wait_n);
      e2  = e;
      if (is_fetch && rdy) begin e2.ir_write = 1'b1; e2.pc_write = 1'b1; end
      cycle(name, rdy, 1'b0, e2);
      if (rdy) return;
      if (i + 1 == T) begin dead = 1'b1; return; end
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic zero, input int fwait,
                           input int mwait, output logic dead);
    exp_t       e;
    logic [5:0] op, fn;
    logic [3:0] alu;
    logic       fn_ok;
    op = ins[31:26];
    fn = ins[5:0];
    bus.instruction = ins;
    e = '0; e.mem_req = 1'b1;
    mem_access("fetch", fwait, e, 1'b1, dead);
    if (dead) return;
    cycle("decode", 1'b1, zero, '0);
    case (op)
      6'h00: begin
        fn_ok = 1'b1;
        case (fn)
          6'h20: alu = 4'b0010;
          6'h22: alu = 4'b0110;
          6'h24: alu = 4'b0000;
          6'h25: alu = 4'b0001;
          6'h2A: alu = 4'b0111;
          default: begin alu = 4'b0000; fn_ok = 1'b0; end
        endcase
        e = '0; e.alu = alu;
        cycle("exec_r", 1'b1, zero, e);
        if (!fn_ok) begin dead = 1'b1; return; end
        e.reg_write = 1'b1; e.reg_dst = 1'b1;
        cycle("wb_r", 1'b1, zero, e);
      end
      6'h23, 6'h2B, 6'h08: begin
        e = '0; e.alu_src = 1'b1; e.alu = 4'b0010;
        cycle("addr", 1'b1, zero, e);
        if (op == 6'h08) begin
          e.reg_write = 1'b1;
          cycle("wb_i", 1'b1, zero, e);
        end else begin
          e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (op == 6'h2B);
          mem_access(op == 6'h2B ? "mem_wr" : "mem_rd", mwait, e, 1'b0, dead);
          if (dead) return;
          if (op == 6'h23) begin
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            cycle("wb_mem", 1'b1, zero, e);
          end
        end
      end
      6'h04: begin
        e = '0; e.alu = 4'b0110; e.pc_branch = zero;
        cycle("branch", 1'b1, zero, e);
      end
      default: begin dead = 1'b1; return; end
    endcase
    model_cnt++;
  endtask

  task automatic error_phase(input int n);
    exp_t e;
    e = '0; e.err = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.instruction = $urandom;
      cycle("error_hold", 1'($urandom_range(1)), 1'($urandom_range(1)), e);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", act(), 16'h0);
    check("async_rst_count", bus.instr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    model_cnt = '0;
    cyc = 0;
    cycle("idle", 1'b1, 1'b0, '0);
  endtask

  initial begin
    exp_t e;
    clk = 1'b0; rst = 1'b1;
    bus.instruction = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    checks = 0; passes = 0; model_cnt = '0;
    cyc = 0; req_cycles = 0; we_cycles = 0; regw_cycles = 0;
    #1;
    check("reset_outputs", act(), 16'h0);
    check("reset_count", bus.instr_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle("idle", 1'b1, 1'b0, '0);

    run_instr(32'h8C010002, 1'b0, 0, 0, died);
    check("lw_retired_literal", bus.instr_count, 1);
    check("lw_cycles_literal", cyc, 6);

    run_instr(32'h00220820, 1'b0, 0, 0, died);
    run_instr(32'h00221022, 1'b0, 0, 0, died);
    run_instr(32'h00221024, 1'b0, 0, 0, died);
    run_instr(32'h00221025, 1'b0, 0, 0, died);
    run_instr(32'h0022102A, 1'b0, 0, 0, died);
    run_instr(32'h20220005, 1'b0, 0, 0, died);
    run_instr(32'h10220003, 1'b1, 0, 0, died);
    run_instr(32'h10220003, 1'b0, 0, 0, died);
    check("after_beq_literal", bus.instr_count, 9);

    req_cycles = 0; we_cycles = 0; regw_cycles = 0;
    run_instr(32'hAC010004, 1'b0, 0, 3, died);
    check("sw_we_cycles", we_cycles, 4);
    check("sw_req_cycles", req_cycles, 5);
    check("sw_no_regwrite", regw_cycles, 0);

    // Stalls end exactly on the watchdog's last cycle: ready must win.
    run_instr(32'h8C010002, 1'b0, 3, 3, died);
    check("ready_wins_no_error", bus.error, 0);

    for (int i = 0; i < 6; i++) run_instr(32'h10220003, 1'(i % 2), 0, 0, died);
    check("count_wrap_literal", bus.instr_count, 1);

    req_cycles = 0;
    run_instr(32'h8C010002, 1'b0, 99, 0, died);
    check("fetch_timeout_req_cycles", req_cycles, T);
    check("fetch_timeout_error", bus.error, 1);
    error_phase(4);
    do_reset();

    run_instr(32'h8C010002, 1'b0, 0, 99, died);
    check("memrd_timeout_error", bus.error, 1);
    error_phase(2);
    do_reset();

    run_instr(32'hFC000000, 1'b0, 0, 0, died);
    check("bad_opcode_error", bus.error, 1);
    error_phase(2);
    do_reset();

    run_instr(32'h00220800, 1'b0, 0, 0, died);
    check("bad_funct_error", bus.error, 1);
    error_phase(2);
    do_reset();

    // Reset in the middle of a stalled data read.
    bus.instruction = 32'h8C010002;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cycle("fetch", 1'b1, 1'b0, e);
    cycle("decode", 1'b1, 1'b0, '0);
    e = '0; e.alu_src = 1'b1; e.alu = 4'b0010;
    cycle("addr", 1'b1, 1'b0, e);
    e.mem_req = 1'b1; e.iord = 1'b1;
    cycle("mem_rd", 1'b0, 1'b0, e);
    cycle("mem_rd", 1'b0, 1'b0, e);
    bus.mem_ready = 1'b0;
    do_reset();
    run_instr(32'h00220820, 1'b0, 0, 0, died);
    check("post_reset_retire", bus.instr_count, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
